pc_sp_mem_unit: RTL and testbench

//  Parametrised PC/SP register pair with unified word memory, driven by a command/response handshake.

---
 rtl/pc_sp_mem_unit_if.sv | 39 +++
 rtl/pc_sp_mem_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_pc_sp_mem_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sp_mem_unit_if.sv
// Command/response bus of the PC/SP memory unit.
// master: control FSM side (issues commands, consumes responses)
// slave : pc_sp_mem_unit side
interface pc_sp_mem_unit_if #(
    parameter int unsigned DATA_W = 16
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rdata;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_addr,
        output cmd_wdata,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_err,
        input  rdata
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_addr,
        input  cmd_wdata,
        output cmd_ready,
        output rsp_valid,
        output rsp_err,
        output rdata
    );

endinterface

// File: rtl/pc_sp_mem_unit.sv
// PC/SP register pair with a unified word memory behind a command/response
// handshake. Ops: FETCH, LOAD, STORE, PUSH, POP, JUMP, SP_SET (op 7 illegal).
// Every op runs IDLE -> BUSY (WAIT_STATES+1 cycles) -> RESP -> IDLE.
// PC/SP are byte addresses; memory is word-indexed by addr[ADDR_W:1], so
// DATA_W must exceed ADDR_W.
// Optional feature macro: PC_SP_MEM_STACK_BOUNDS_EN -- when defined, PUSH,
// POP and SP_SET are checked against [STACK_LO, SP_INIT]; when undefined the
// stack pointer simply wraps.
module pc_sp_mem_unit #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       ADDR_W      = 10,
    parameter logic [DATA_W-1:0] PC_INIT     = 16'h0000,
    parameter logic [DATA_W-1:0] SP_INIT     = 16'h07FE,
    parameter logic [DATA_W-1:0] STACK_LO    = 16'h0600,
    parameter int unsigned       WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    pc_sp_mem_unit_if.slave   bus,
    output logic [DATA_W-1:0] inst_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] sp_out
);

    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] STEP      = DATA_W'(2);
    localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_STATES);

`ifdef PC_SP_MEM_STACK_BOUNDS_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    typedef enum logic [2:0] {
        OP_FETCH   = 3'd0,
        OP_LOAD    = 3'd1,
        OP_STORE   = 3'd2,
        OP_PUSH    = 3'd3,
        OP_POP     = 3'd4,
        OP_JUMP    = 3'd5,
        OP_SP_SET  = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_t;

    // Word memory; no reset so contents survive reset_n.
    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    op_t               op_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        count;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] sp;
    logic [DATA_W-1:0] inst_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;

    logic [DATA_W-1:0] sp_dec;
    logic [DATA_W-1:0] sp_inc;
    logic [DATA_W-1:0] pc_inc;
    logic              push_oob;
    logic              pop_oob;
    logic              set_oob;

    logic [ADDR_W-1:0] word_idx;
    logic              op_err;
    logic              op_writes;
    logic              fire;
    logic              mem_we;

    assign sp_dec = sp - STEP;
    assign sp_inc = sp + STEP;
    assign pc_inc = pc + STEP;

    // Stack bound violations; forced low when the bounds feature is off.
    assign push_oob = BOUNDS_EN && (sp_dec < STACK_LO);
    assign pop_oob  = BOUNDS_EN && (sp >= SP_INIT);
    assign set_oob  = BOUNDS_EN && ((addr_q < STACK_LO) || (addr_q > SP_INIT));

    // Idle unit accepts commands, but never while reset is held.
    assign bus.cmd_ready = reset_n && (state == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rdata     = rdata_q;

    assign inst_out = inst_q;
    assign pc_out   = pc;
    assign sp_out   = sp;

    // Decode the latched op: memory word touched, error status, write intent.
    always_comb begin
        word_idx  = '0;
        op_err    = 1'b0;
        op_writes = 1'b0;
        case (op_q)
            OP_FETCH: begin
                word_idx = pc[ADDR_W:1];
            end
            OP_LOAD: begin
                word_idx = addr_q[ADDR_W:1];
                op_err   = addr_q[0];
            end
            OP_STORE: begin
                word_idx  = addr_q[ADDR_W:1];
                op_err    = addr_q[0];
                op_writes = 1'b1;
            end
            OP_PUSH: begin
                word_idx  = sp_dec[ADDR_W:1];
                op_err    = push_oob;
                op_writes = 1'b1;
            end
            OP_POP: begin
                word_idx = sp[ADDR_W:1];
                op_err   = pop_oob;
            end
            OP_JUMP: begin
                op_err = addr_q[0];
            end
            OP_SP_SET: begin
                op_err = addr_q[0] || set_oob;
            end
            default: begin
                op_err = 1'b1;
            end
        endcase
    end

    // Execute edge: last BUSY cycle. The reset_n term keeps an aborted
    // STORE/PUSH from writing on the edge where reset is sampled.
    assign fire   = (state == S_BUSY) && (count == '0);
    assign mem_we = reset_n && fire && op_writes && !op_err;

    // Memory write port.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[word_idx] <= wdata_q;
        end
    end

    // Control FSM with registered PC/SP, fetch/read data and response flags.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            op_q        <= OP_FETCH;
            addr_q      <= '0;
            wdata_q     <= '0;
            count       <= '0;
            pc          <= PC_INIT;
            sp          <= SP_INIT;
            inst_q      <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    if (bus.cmd_valid) begin
                        op_q    <= op_t'(bus.cmd_op);
                        addr_q  <= bus.cmd_addr;
                        wdata_q <= bus.cmd_wdata;
                        count   <= WAIT_LOAD;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (count != '0) begin
                        count <= count - 4'd1;
                    end else begin
                        if (!op_err) begin
                            case (op_q)
                                OP_FETCH: begin
                                    inst_q <= mem[word_idx];
                                    pc     <= pc_inc;
                                end
                                OP_LOAD: begin
                                    rdata_q <= mem[word_idx];
                                end
                                OP_PUSH: begin
                                    sp <= sp_dec;
                                end
                                OP_POP: begin
                                    rdata_q <= mem[word_idx];
                                    sp      <= sp_inc;
                                end
                                OP_JUMP: begin
                                    pc <= addr_q;
                                end
                                OP_SP_SET: begin
                                    sp <= addr_q;
                                end
                                default: begin
                                end
                            endcase
                        end
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= op_err;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sp_mem_unit.sv
// Scoreboard bench for pc_sp_mem_unit: a reference model computes the
// expected response of every issued command and queues it; a monitor pops
// and compares on each rsp_valid pulse. Stack bound cases follow
// PC_SP_MEM_STACK_BOUNDS_EN the same way the design does.
module tb_pc_sp_mem_unit;

    localparam int unsigned  WS       = 1;
    localparam logic [15:0]  PC_INIT  = 16'h0000;
    localparam logic [15:0]  SP_INIT  = 16'h07FE;
    localparam logic [15:0]  STACK_LO = 16'h0600;

    localparam logic [2:0] OP_FETCH  = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_PUSH   = 3'd3;
    localparam logic [2:0] OP_POP    = 3'd4;
    localparam logic [2:0] OP_JUMP   = 3'd5;
    localparam logic [2:0] OP_SP_SET = 3'd6;
    localparam logic [2:0] OP_ILL    = 3'd7;

    logic clock;
    logic reset_n;
    logic [15:0] inst_out;
    logic [15:0] pc_out;
    logic [15:0] sp_out;

    pc_sp_mem_unit_if #(.DATA_W(16)) bus ();

    pc_sp_mem_unit #(
        .DATA_W     (16),
        .ADDR_W     (10),
        .PC_INIT    (PC_INIT),
        .SP_INIT    (SP_INIT),
        .STACK_LO   (STACK_LO),
        .WAIT_STATES(WS)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .inst_out(inst_out),
        .pc_out  (pc_out),
        .sp_out  (sp_out)
    );

    typedef struct {
        logic [2:0]  op;
        logic        err;
        logic [15:0] rdata;
        logic [15:0] inst;
        logic [15:0] pc;
        logic [15:0] sp;
        int          acc;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state
    logic [15:0] m_mem [1024];
    logic [15:0] m_pc;
    logic [15:0] m_sp;
    logic [15:0] m_inst;
    logic [15:0] m_rdata;

`ifdef PC_SP_MEM_STACK_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = PC_INIT;
        m_sp    = SP_INIT;
        m_inst  = '0;
        m_rdata = '0;
    endtask

    task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] w,
                         output exp_t e);
        logic        err;
        logic [15:0] nsp;
        err = 1'b0;
        nsp = m_sp - 16'd2;
        case (op)
            OP_FETCH: begin
                m_inst = m_mem[m_pc[10:1]];
                m_pc   = m_pc + 16'd2;
            end
            OP_LOAD:  if (a[0]) err = 1'b1; else m_rdata = m_mem[a[10:1]];
            OP_STORE: if (a[0]) err = 1'b1; else m_mem[a[10:1]] = w;
            OP_PUSH: begin
                if (BOUNDS && nsp < STACK_LO) err = 1'b1;
                else begin
                    m_sp = nsp;
                    m_mem[nsp[10:1]] = w;
                end
            end
            OP_POP: begin
                if (BOUNDS && m_sp >= SP_INIT) err = 1'b1;
                else begin
                    m_rdata = m_mem[m_sp[10:1]];
                    m_sp    = m_sp + 16'd2;
                end
            end
            OP_JUMP: if (a[0]) err = 1'b1; else m_pc = a;
            OP_SP_SET: begin
                if (a[0] || (BOUNDS && (a < STACK_LO || a > SP_INIT))) err = 1'b1;
                else m_sp = a;
            end
            default: err = 1'b1;
        endcase
        e.op    = op;
        e.err   = err;
        e.rdata = m_rdata;
        e.inst  = m_inst;
        e.pc    = m_pc;
        e.sp    = m_sp;
        e.acc   = 0;
    endtask

    // Wait for the unit to be ready, queue the expected result, and present
    // the command for exactly one accepting edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] w);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clock);
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            check("ready_timeout", 32'(bus.cmd_ready), 32'd1);
            return;
        end
        model(op, a, w, e);
        e.acc = cyc + 1;
        sb.push_back(e);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_wdata = w;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest queued op.
    always @(negedge clock) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_rsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("op%0d_err", e.op),     32'(bus.rsp_err), 32'(e.err));
                check($sformatf("op%0d_rdata", e.op),   32'(bus.rdata),   32'(e.rdata));
                check($sformatf("op%0d_inst", e.op),    32'(inst_out),    32'(e.inst));
                check($sformatf("op%0d_pc", e.op),      32'(pc_out),      32'(e.pc));
                check($sformatf("op%0d_sp", e.op),      32'(sp_out),      32'(e.sp));
                check($sformatf("op%0d_latency", e.op), 32'(cyc - e.acc), 32'(1 + WS));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "simulation time limit");
    end

    initial begin
        foreach (m_mem[i]) m_mem[i] = '0;
        model_reset();
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        repeat (3) @(negedge clock);
        check("ready_in_reset", 32'(bus.cmd_ready), 32'd0);
        check("rsp_in_reset",   32'(bus.rsp_valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_pc",    32'(pc_out),        32'(PC_INIT));
        check("rst_sp",    32'(sp_out),        32'(SP_INIT));
        check("rst_inst",  32'(inst_out),      32'd0);
        check("rst_rdata", 32'(bus.rdata),     32'd0);
        check("rst_err",   32'(bus.rsp_err),   32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);

        // program words A,B,C at 0,2,4 then fetch them back
        issue(OP_STORE, 16'h0000, 16'hA0A0);
        issue(OP_STORE, 16'h0002, 16'hB1B1);
        issue(OP_STORE, 16'h0004, 16'hC2C2);
        repeat (3) issue(OP_FETCH, 16'h0000, 16'h0000);

        // store/load sweep
        for (int i = 0; i < 16; i++) issue(OP_STORE, 16'(30 + 2 * i), 16'(i));
        for (int i = 0; i < 16; i++) issue(OP_LOAD,  16'(30 + 2 * i), 16'h0000);

        // stack round trip
        for (int i = 0; i < 16; i++) issue(OP_PUSH, 16'h0000, 16'(i));
        for (int i = 0; i < 16; i++) issue(OP_POP,  16'h0000, 16'h0000);
        drain();
        check("stack_sp_back", 32'(sp_out), 32'(SP_INIT));

        // stack bounds (error with bounds enabled, wraps normally otherwise)
        issue(OP_SP_SET, STACK_LO, 16'h0000);
        issue(OP_PUSH, 16'h0000, 16'h0005);
        issue(OP_STORE, SP_INIT, 16'h5A5A);
        issue(OP_SP_SET, SP_INIT, 16'h0000);
        issue(OP_POP, 16'h0000, 16'h0000);
        issue(OP_SP_SET, 16'h0800, 16'h0000);
        issue(OP_SP_SET, 16'h0700, 16'h0000);

        // illegal op, odd addresses, jump
        issue(OP_LOAD, 16'h0020, 16'h0000);
        issue(OP_ILL, 16'h0000, 16'h0000);
        issue(OP_LOAD, 16'h0021, 16'h0000);
        issue(OP_STORE, 16'h0023, 16'hDEAD);
        issue(OP_JUMP, 16'h0101, 16'h0000);
        issue(OP_SP_SET, 16'h0601, 16'h0000);
        issue(OP_JUMP, 16'h0002, 16'h0000);
        issue(OP_FETCH, 16'h0000, 16'h0000);
        issue(OP_JUMP, 16'hFFFE, 16'h0000);
        issue(OP_FETCH, 16'h0000, 16'h0000);

        // reset aborts an in-flight STORE
        issue(OP_STORE, 16'h0040, 16'h1234);
        drain();
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_STORE;
        bus.cmd_addr  = 16'h0040;
        bus.cmd_wdata = 16'hBEEF;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("abort_ready_low", 32'(bus.cmd_ready), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        @(negedge clock);
        check("abort_pc", 32'(pc_out), 32'(PC_INIT));
        check("abort_sp", 32'(sp_out), 32'(SP_INIT));
        issue(OP_LOAD, 16'h0040, 16'h0000);
        drain();

        repeat (4) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
